// File: rtl/exec_pkg.sv
// exec_pkg: shared widths, opcodes, FSM encoding and the single-cycle ALU
// function for the exec_unit execute/writeback stage.
// Bit 0 of every data/address vector is the MSB.
package exec_pkg;

    localparam int DATA_W  = 48;
    localparam int ADR_W   = 2;
    localparam int MUL_CYC = 48;   // one shift-add step per multiplier bit
    localparam int SHAMT_W = 6;    // SHL uses the low 6 bits of operand B

    typedef logic [0:DATA_W-1] data_t;
    typedef logic [0:ADR_W-1]  adr_t;
    typedef logic [0:2]        op_t;

    localparam op_t OP_ADD  = 3'b000;
    localparam op_t OP_SUB  = 3'b001;
    localparam op_t OP_AND  = 3'b010;
    localparam op_t OP_OR   = 3'b011;
    localparam op_t OP_XOR  = 3'b100;
    localparam op_t OP_SHL  = 3'b101;
    localparam op_t OP_MUL  = 3'b110;
    localparam op_t OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WB       = 2'd1,
        S_EXEC_MUL = 2'd2
    } state_t;

    typedef struct packed {
        data_t res;
        logic  carry;   // carry-out for ADD, borrow for SUB
    } alu_out_t;

    // Single-cycle ALU; MUL is produced by the iterative multiplier instead.
    function automatic alu_out_t alu_eval(op_t op, data_t a, data_t b);
        alu_out_t             o;
        logic [DATA_W:0]      ext;
        logic [SHAMT_W-1:0]   shamt;
        o.res   = '0;
        o.carry = 1'b0;
        ext     = '0;
        shamt   = b[DATA_W-SHAMT_W:DATA_W-1];
        case (op)
            OP_ADD: begin
                ext     = {1'b0, a} + {1'b0, b};
                o.res   = ext[DATA_W-1:0];
                o.carry = ext[DATA_W];
            end
            OP_SUB: begin
                // The extra top bit goes high exactly when a < b.
                ext     = {1'b0, a} - {1'b0, b};
                o.res   = ext[DATA_W-1:0];
                o.carry = ext[DATA_W];
            end
            OP_AND:  o.res = a & b;
            OP_OR:   o.res = a | b;
            OP_XOR:  o.res = a ^ b;
            OP_SHL:  o.res = (shamt > SHAMT_W'(DATA_W - 1)) ? '0 : (a << shamt);
            OP_MUL:  o.res = '0;
            default: o.res = a;   // PASS
        endcase
        return o;
    endfunction

endpackage

// File: rtl/exec_unit_if.sv
// exec_unit_if: issue handshake plus the register_file read/write ports.
// The master side is the issuer together with the register file; the slave
// side is exec_unit.
interface exec_unit_if;
    import exec_pkg::*;

    logic  issue_valid;
    logic  issue_ready;
    op_t   issue_op;
    adr_t  issue_rs_a;
    adr_t  issue_rs_b;
    adr_t  issue_rd;
    adr_t  read_adr_a;
    adr_t  read_adr_b;
    data_t reg_a;
    data_t reg_b;
    logic  write_en;
    adr_t  write_adr;
    data_t write_data;

    modport master (
        output issue_valid, issue_op, issue_rs_a, issue_rs_b, issue_rd,
        output reg_a, reg_b,
        input  issue_ready, read_adr_a, read_adr_b,
        input  write_en, write_adr, write_data
    );

    modport slave (
        input  issue_valid, issue_op, issue_rs_a, issue_rs_b, issue_rd,
        input  reg_a, reg_b,
        output issue_ready, read_adr_a, read_adr_b,
        output write_en, write_adr, write_data
    );

endinterface

// File: rtl/exec_unit_mul_iter.sv
// exec_unit_mul_iter (mul_iter): iterative shift-add multiplier, MUL_CYC steps,
// low DATA_W bits of a*b. start_i loads operands; done_o is high in the cycle
// whose step is the last one, with prod_o already holding the final product,
// so the caller can write it back on that same edge.
module exec_unit_mul_iter
    import exec_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr_i,
    input  logic  start_i,
    input  data_t a_i,
    input  data_t b_i,
    output logic  done_o,
    output data_t prod_o
);

    localparam int              CNT_W = $clog2(MUL_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYC - 1);

    data_t            mcand_q;
    data_t            mplier_q;
    data_t            acc_q;
    data_t            acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    // One step: add the shifted multiplicand when the current multiplier LSB is set.
    always_comb begin
        acc_d = acc_q + (mplier_q[DATA_W-1] ? mcand_q : '0);
    end

    assign done_o = run_q && (cnt_q == LAST);
    assign prod_o = acc_d;

    // Operand load, per-cycle iteration and FSM-driven clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (clr_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute/writeback stage behind register_file. Accepts one
// instruction per handshake, reads operands combinationally through the
// register file, and writes a 48-bit result back one cycle later (MUL_CYC+1
// cycles later for MUL).
// Optional build macro EXEC_FWD_EN: accept during writeback and bypass the
// value being written into the operands of the newly accepted instruction.
module exec_unit
    import exec_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    exec_unit_if.slave   bus,
    output logic         flag_z,
    output logic         flag_c,
    output logic         busy
);

    state_t   state_q;
    adr_t     rd_q;
    logic     write_en_q;
    adr_t     write_adr_q;
    data_t    write_data_q;
    logic     flag_z_q;
    logic     flag_c_q;
    logic     busy_q;

    logic     ready_d;
    logic     accept_d;
    data_t    opnd_a_d;
    data_t    opnd_b_d;
    alu_out_t alu_d;
    logic     mul_start;
    logic     mul_clr;
    logic     mul_done;
    data_t    mul_prod;

    assign bus.read_adr_a = bus.issue_rs_a;
    assign bus.read_adr_b = bus.issue_rs_b;

    // Ready is low while reset is held, during MUL, and (without bypass) in
    // writeback so the register file commits before the next read.
    always_comb begin
        ready_d = 1'b0;
        if (!rst) begin
`ifdef EXEC_FWD_EN
            ready_d = (state_q == S_IDLE) || (state_q == S_WB);
`else
            ready_d = (state_q == S_IDLE);
`endif
        end
    end

    assign accept_d        = bus.issue_valid && ready_d;
    assign bus.issue_ready = ready_d;

    // Operand selection: register file value, or the value committing this cycle.
    always_comb begin
        opnd_a_d = bus.reg_a;
        opnd_b_d = bus.reg_b;
`ifdef EXEC_FWD_EN
        if (write_en_q && (bus.issue_rs_a == write_adr_q)) begin
            opnd_a_d = write_data_q;
        end
        if (write_en_q && (bus.issue_rs_b == write_adr_q)) begin
            opnd_b_d = write_data_q;
        end
`endif
    end

    // Single-cycle result for every non-MUL opcode.
    always_comb begin
        alu_d = alu_eval(bus.issue_op, opnd_a_d, opnd_b_d);
    end

    assign mul_start = accept_d && (bus.issue_op == OP_MUL);
    assign mul_clr   = (state_q == S_WB);

    exec_unit_mul_iter u_mul_iter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (mul_clr),
        .start_i (mul_start),
        .a_i     (opnd_a_d),
        .b_i     (opnd_b_d),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    // Control FSM with registered writeback strobe, data, flags and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rd_q         <= '0;
            write_en_q   <= 1'b0;
            write_adr_q  <= '0;
            write_data_q <= '0;
            flag_z_q     <= 1'b0;
            flag_c_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            write_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_WB: begin
                    if (accept_d) begin
                        if (bus.issue_op == OP_MUL) begin
                            state_q <= S_EXEC_MUL;
                            busy_q  <= 1'b1;
                            rd_q    <= bus.issue_rd;
                        end else begin
                            state_q      <= S_WB;
                            write_en_q   <= 1'b1;
                            write_adr_q  <= bus.issue_rd;
                            write_data_q <= alu_d.res;
                            flag_z_q     <= (alu_d.res == '0);
                            if ((bus.issue_op == OP_ADD) || (bus.issue_op == OP_SUB)) begin
                                flag_c_q <= alu_d.carry;
                            end
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_EXEC_MUL: begin
                    if (mul_done) begin
                        state_q      <= S_WB;
                        busy_q       <= 1'b0;
                        write_en_q   <= 1'b1;
                        write_adr_q  <= rd_q;
                        write_data_q <= mul_prod;
                        flag_z_q     <= (mul_prod == '0);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.write_en   = write_en_q;
    assign bus.write_adr  = write_adr_q;
    assign bus.write_data = write_data_q;
    assign flag_z         = flag_z_q;
    assign flag_c         = flag_c_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: self-checking bench for exec_unit. Holds a 4-entry register
// file model, a directed vector table, hand-written multi-cycle sequences and
// a randomized run checked against an arithmetic reference model.
module tb_exec_unit;
    import exec_pkg::*;

`ifdef EXEC_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif
    localparam longint unsigned MASK = 64'h0000_FFFF_FFFF_FFFF;

    logic clk;
    logic rst;
    logic flag_z;
    logic flag_c;
    logic busy;

    exec_unit_if bus ();

    exec_unit dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: preload port for the bench, write port from the DUT.
    data_t           rf [4];
    logic            pre_en;
    longint unsigned pre_val [4];

    always @(posedge clk) begin
        if (pre_en) begin
            for (int j = 0; j < 4; j++) rf[j] <= data_t'(pre_val[j]);
        end else if (bus.write_en) begin
            rf[bus.write_adr] <= bus.write_data;
        end
    end

    always_comb begin
        bus.reg_a = rf[bus.read_adr_a];
        bus.reg_b = rf[bus.read_adr_b];
    end

    int  n_pass;
    int  n_total;
    bit  mc;   // expected carry flag, carried across the whole run

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic preload4(input longint unsigned v0, v1, v2, v3);
        @(negedge clk);
        pre_val[0] = v0; pre_val[1] = v1; pre_val[2] = v2; pre_val[3] = v3;
        pre_en = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic do_issue(input op_t op, input logic [1:0] ra, rb, rd);
        int n;
        n = 0;
        @(negedge clk);
        bus.issue_op = op; bus.issue_rs_a = ra; bus.issue_rs_b = rb; bus.issue_rd = rd;
        bus.issue_valid = 1'b1;
        while (!bus.issue_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("issue_ready_wait", bus.issue_ready, 1);
        @(posedge clk);
        #1 bus.issue_valid = 1'b0;
    endtask

    // Waits for the write strobe counting cycles after the accept edge.
    task automatic check_write(input string nm, input int lat, input logic [1:0] adr,
                               input longint unsigned d, input bit c, input bit is_mul);
        int k;
        bit busy_ok;
        busy_ok = 1'b1;
        @(negedge clk);
        k = 1;
        while (!bus.write_en && k < 100) begin
            if (!(busy && !bus.issue_ready)) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        chk({nm, "_lat"}, k, lat);
        chk({nm, "_adr"}, bus.write_adr, adr);
        chk({nm, "_data"}, bus.write_data, d);
        chk({nm, "_z"}, flag_z, (d == 0));
        chk({nm, "_c"}, flag_c, c);
        if (is_mul) chk({nm, "_busy"}, busy_ok, 1);
    endtask

    // Reference model written from the opcode definitions with plain arithmetic.
    function automatic void model(input op_t op, input longint unsigned a, b,
                                  output longint unsigned r, output bit c, output bit upd);
        longint unsigned s;
        c = 1'b0; upd = 1'b0; r = 0;
        case (op)
            OP_ADD:  begin s = a + b; r = s & MASK; c = (s > MASK); upd = 1'b1; end
            OP_SUB:  begin r = (a - b) & MASK; c = (a < b); upd = 1'b1; end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SHL:  begin s = b % 64; r = (s >= 48) ? 0 : ((a << s) & MASK); end
            OP_MUL:  r = (a * b) & MASK;
            default: r = a;
        endcase
    endfunction

    typedef struct {
        op_t             op;
        logic [1:0]      ra, rb, rd;
        longint unsigned va, vb, ed;
        bit              ec;
    } vec_t;

    vec_t tv [17];

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        longint unsigned pv [4];
        longint unsigned mrf [4];
        longint unsigned r;
        bit c, upd, wr_seen, busy_ok;
        int k, g;
        op_t op;
        logic [1:0] ra, rb, rd;

        n_pass = 0; n_total = 0; mc = 1'b0;
        pre_en = 1'b0;
        for (int j = 0; j < 4; j++) pre_val[j] = 0;
        bus.issue_valid = 1'b0; bus.issue_op = OP_ADD;
        bus.issue_rs_a = '0; bus.issue_rs_b = '0; bus.issue_rd = '0;

        tv[0]  = '{OP_ADD,  2'd0, 2'd1, 2'd2, 64'h1, 64'h2, 64'h3, 1'b0};
        tv[1]  = '{OP_SUB,  2'd0, 2'd1, 2'd3, 64'h1, 64'h2, 64'hFFFF_FFFF_FFFF, 1'b1};
        tv[2]  = '{OP_XOR,  2'd0, 2'd0, 2'd1, 64'h1, 64'h1, 64'h0, 1'b1};
        tv[3]  = '{OP_ADD,  2'd0, 2'd1, 2'd2, 64'hFFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1};
        tv[4]  = '{OP_AND,  2'd2, 2'd3, 2'd0, 64'hF0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0, 64'h00F0_00F0_00F0, 1'b1};
        tv[5]  = '{OP_SHL,  2'd0, 2'd1, 2'd2, 64'h1, 64'h2F, 64'h8000_0000_0000, 1'b1};
        tv[6]  = '{OP_SHL,  2'd0, 2'd1, 2'd2, 64'h7B, 64'h30, 64'h0, 1'b1};
        tv[7]  = '{OP_SHL,  2'd0, 2'd1, 2'd3, 64'hFFFF_FFFF_FFFF, 64'h40, 64'hFFFF_FFFF_FFFF, 1'b1};
        tv[8]  = '{OP_SHL,  2'd1, 2'd2, 2'd3, 64'h3, 64'h3F, 64'h0, 1'b1};
        tv[9]  = '{OP_MUL,  2'd2, 2'd3, 2'd0, 64'h3, 64'h4, 64'hC, 1'b1};
        tv[10] = '{OP_MUL,  2'd1, 2'd2, 2'd3, 64'hFFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF, 64'h1, 1'b1};
        tv[11] = '{OP_SUB,  2'd2, 2'd1, 2'd0, 64'h5, 64'h3, 64'h2, 1'b0};
        tv[12] = '{OP_OR,   2'd2, 2'd3, 2'd0, 64'hF0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0, 64'hFFF0_FFF0_FFF0, 1'b0};
        tv[13] = '{OP_PASS, 2'd3, 2'd0, 2'd1, 64'hABCD_EF01_2345, 64'h777, 64'hABCD_EF01_2345, 1'b0};
        tv[14] = '{OP_SUB,  2'd1, 2'd2, 2'd1, 64'hA, 64'h3, 64'h7, 1'b0};
        tv[15] = '{OP_SUB,  2'd0, 2'd1, 2'd2, 64'h0, 64'h0, 64'h0, 1'b0};
        tv[16] = '{OP_ADD,  2'd0, 2'd1, 2'd3, 64'h8000_0000_0000, 64'h8000_0000_0000, 64'h0, 1'b1};

        // Power-on reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_write_en", bus.write_en, 0);
        chk("rst_write_adr", bus.write_adr, 0);
        chk("rst_write_data", bus.write_data, 0);
        chk("rst_flag_z", flag_z, 0);
        chk("rst_flag_c", flag_c, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready_held", bus.issue_ready, 0);
        rst = 1'b0;
        #1 chk("rst_ready_release", bus.issue_ready, 1);

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            for (int j = 0; j < 4; j++) pv[j] = 0;
            pv[tv[i].ra] = tv[i].va;
            pv[tv[i].rb] = tv[i].vb;
            preload4(pv[0], pv[1], pv[2], pv[3]);
            do_issue(tv[i].op, tv[i].ra, tv[i].rb, tv[i].rd);
            check_write($sformatf("tv%0d", i), (tv[i].op == OP_MUL) ? 49 : 1,
                        tv[i].rd, tv[i].ed, tv[i].ec, tv[i].op == OP_MUL);
        end

        // Mid-cycle reset while idle clears every output at once
        preload4(1, 2, 3, 4);
        do_issue(OP_SUB, 2'd0, 2'd1, 2'd3);
        check_write("pre_rst_sub", 1, 2'd3, 64'hFFFF_FFFF_FFFF, 1'b1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_write_data", bus.write_data, 0);
        chk("midrst_write_adr", bus.write_adr, 0);
        chk("midrst_flag_c", flag_c, 0);
        chk("midrst_ready", bus.issue_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("midrst_ready_release", bus.issue_ready, 1);
        mc = 1'b0;

        // MUL with issue_valid held: no early accept, then the held ADD
        // reads the freshly written r0 (12 + 2 = 14)
        preload4(1, 2, 3, 4);
        @(negedge clk);
        bus.issue_op = OP_MUL; bus.issue_rs_a = 2'd2; bus.issue_rs_b = 2'd3; bus.issue_rd = 2'd0;
        bus.issue_valid = 1'b1;
        chk("hold_ready_idle", bus.issue_ready, 1);
        @(posedge clk);
        #1 bus.issue_op = OP_ADD; bus.issue_rs_a = 2'd0; bus.issue_rs_b = 2'd1; bus.issue_rd = 2'd2;
        k = 0; busy_ok = 1'b1;
        do begin
            @(negedge clk);
            k++;
            if (!bus.write_en && !(busy && !bus.issue_ready)) busy_ok = 1'b0;
        end while (!bus.write_en && k < 100);
        chk("hold_mul_lat", k, 49);
        chk("hold_mul_adr", bus.write_adr, 0);
        chk("hold_mul_data", bus.write_data, 64'hC);
        chk("hold_mul_busy", busy_ok, 1);
        g = 0;
        while (!bus.issue_ready && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk("hold_gap", g, (FWD != 0) ? 0 : 1);
        @(posedge clk);
        #1 bus.issue_valid = 1'b0;
        check_write("hold_add", 1, 2'd2, 64'hE, 1'b0, 1'b0);

        // Reset at MUL iteration 20 aborts with no writeback
        preload4(1, 2, 3, 4);
        do_issue(OP_MUL, 2'd2, 2'd3, 2'd0);
        wr_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.write_en) wr_seen = 1'b1;
        end
        #2 rst = 1'b1;
        #1 chk("mulrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.write_en) wr_seen = 1'b1;
        end
        chk("mulrst_no_write", wr_seen, 0);
        chk("mulrst_idle_ready", bus.issue_ready, 1);
        chk("mulrst_idle_busy", busy, 0);
        chk("mulrst_r0_kept", rf[0], 1);
        mc = 1'b0;

        // Dependent back-to-back ADDs; stale r2 = 100 would give 200
        preload4(1, 2, 100, 4);
        @(negedge clk);
        bus.issue_op = OP_ADD; bus.issue_rs_a = 2'd0; bus.issue_rs_b = 2'd1; bus.issue_rd = 2'd2;
        bus.issue_valid = 1'b1;
        @(posedge clk);
        #1 bus.issue_rs_a = 2'd2; bus.issue_rs_b = 2'd2; bus.issue_rd = 2'd3;
        @(negedge clk);
        chk("b2b_first_en", bus.write_en, 1);
        chk("b2b_first_adr", bus.write_adr, 2);
        chk("b2b_first_data", bus.write_data, 3);
        g = 0;
        while (!bus.issue_ready && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk("b2b_gap", g, (FWD != 0) ? 0 : 1);
        @(posedge clk);
        #1 bus.issue_valid = 1'b0;
        check_write("b2b_second", 1, 2'd3, 64'h6, 1'b0, 1'b0);

        // Randomized stream against the reference model
        for (int it = 0; it < 60; it++) begin
            if (it % 10 == 0) begin
                for (int j = 0; j < 4; j++)
                    mrf[j] = {32'($urandom), 32'($urandom)} & MASK;
                if (it == 20) mrf[1] = 64'h35;   // exercise a large SHL amount
                preload4(mrf[0], mrf[1], mrf[2], mrf[3]);
            end
            op = 3'($urandom_range(0, 7));
            ra = 2'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            rd = 2'($urandom_range(0, 3));
            model(op, mrf[ra], mrf[rb], r, c, upd);
            if (upd) mc = c;
            mrf[rd] = r;
            do_issue(op, ra, rb, rd);
            check_write($sformatf("rnd%0d", it), (op == OP_MUL) ? 49 : 1, rd, r, mc, op == OP_MUL);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
